// File: rtl/lsu_mem_port.sv
// MEM-stage load/store responder for the multi-cycle datapath: aligns store lanes,
// extracts/extends load data into the MDR and runs a bounded memory handshake.
module lsu_mem_port #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        we,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic [31:0] mdr,
    output logic        done,
    output logic        err,
    output logic        busy
);

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] LastCount = CNT_W'(TIMEOUT - 1);

    state_t           state_q,     state_d;
    logic [CNT_W-1:0] cnt_q,       cnt_d;
    logic [2:0]       funct3_q,    funct3_d;
    logic [1:0]       offset_q,    offset_d;
    logic             memReq_q,    memReq_d;
    logic             memWe_q,     memWe_d;
    logic [31:0]      memAddr_q,   memAddr_d;
    logic [31:0]      memWdata_q,  memWdata_d;
    logic [3:0]       memWstrb_q,  memWstrb_d;
    logic [31:0]      mdr_q,       mdr_d;
    logic             done_q,      done_d;
    logic             err_q,       err_d;
    logic             busy_q,      busy_d;

    logic             cmdLegal;
    logic             cmdAligned;
    logic [3:0]       stWstrb;
    logic [31:0]      stWdata;
    logic [31:0]      ldLane;
    logic [31:0]      ldValue;

    // Stores only support byte/half/word; loads additionally allow the unsigned forms.
    always_comb begin
        cmdLegal = 1'b0;
        if (we) begin
            case (funct3)
                3'b000, 3'b001, 3'b010: cmdLegal = 1'b1;
                default:                cmdLegal = 1'b0;
            endcase
        end else begin
            case (funct3)
                3'b000, 3'b001, 3'b010, 3'b100, 3'b101: cmdLegal = 1'b1;
                default:                                cmdLegal = 1'b0;
            endcase
        end
    end

    always_comb begin
        cmdAligned = 1'b1;
        case (funct3[1:0])
            2'b01:   cmdAligned = ~addr[0];
            2'b10:   cmdAligned = (addr[1:0] == 2'b00);
            default: cmdAligned = 1'b1;
        endcase
    end

    // Store data is replicated across lanes so the strobes alone select the target bytes.
    always_comb begin
        stWstrb = 4'b0000;
        stWdata = 32'h0000_0000;
        case (funct3[1:0])
            2'b00: begin
                stWstrb = 4'b0001 << addr[1:0];
                stWdata = {4{wdata[7:0]}};
            end
            2'b01: begin
                stWstrb = addr[1] ? 4'b1100 : 4'b0011;
                stWdata = {2{wdata[15:0]}};
            end
            default: begin
                stWstrb = 4'b1111;
                stWdata = wdata;
            end
        endcase
    end

    assign ldLane = mem_rdata >> {offset_q, 3'b000};

    always_comb begin
        case (funct3_q)
            3'b000:  ldValue = {{24{ldLane[7]}}, ldLane[7:0]};
            3'b100:  ldValue = {24'h00_0000, ldLane[7:0]};
            3'b001:  ldValue = {{16{ldLane[15]}}, ldLane[15:0]};
            3'b101:  ldValue = {16'h0000, ldLane[15:0]};
            default: ldValue = ldLane;
        endcase
    end

    // An ack is checked before the timeout so a late ack still completes cleanly.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        funct3_d   = funct3_q;
        offset_d   = offset_q;
        memReq_d   = memReq_q;
        memWe_d    = memWe_q;
        memAddr_d  = memAddr_q;
        memWdata_d = memWdata_q;
        memWstrb_d = memWstrb_q;
        mdr_d      = mdr_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        busy_d     = busy_q;

        case (state_q)
            IDLE: begin
                if (req) begin
                    if (!cmdLegal || !cmdAligned) begin
                        done_d = 1'b1;
                        err_d  = 1'b1;
                    end else begin
                        state_d    = WAIT;
                        cnt_d      = '0;
                        funct3_d   = funct3;
                        offset_d   = addr[1:0];
                        memReq_d   = 1'b1;
                        memWe_d    = we;
                        memAddr_d  = {addr[31:2], 2'b00};
                        memWdata_d = we ? stWdata : 32'h0000_0000;
                        memWstrb_d = we ? stWstrb : 4'b0000;
                        busy_d     = 1'b1;
                    end
                end
            end
            WAIT: begin
                if (mem_ack) begin
                    state_d  = IDLE;
                    cnt_d    = '0;
                    memReq_d = 1'b0;
                    busy_d   = 1'b0;
                    done_d   = 1'b1;
                    if (!memWe_q) begin
                        mdr_d = ldValue;
                    end
                end else if (cnt_q == LastCount) begin
                    state_d  = IDLE;
                    cnt_d    = '0;
                    memReq_d = 1'b0;
                    busy_d   = 1'b0;
                    done_d   = 1'b1;
                    err_d    = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            funct3_q   <= 3'b000;
            offset_q   <= 2'b00;
            memReq_q   <= 1'b0;
            memWe_q    <= 1'b0;
            memAddr_q  <= 32'h0000_0000;
            memWdata_q <= 32'h0000_0000;
            memWstrb_q <= 4'b0000;
            mdr_q      <= 32'h0000_0000;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            funct3_q   <= funct3_d;
            offset_q   <= offset_d;
            memReq_q   <= memReq_d;
            memWe_q    <= memWe_d;
            memAddr_q  <= memAddr_d;
            memWdata_q <= memWdata_d;
            memWstrb_q <= memWstrb_d;
            mdr_q      <= mdr_d;
            done_q     <= done_d;
            err_q      <= err_d;
            busy_q     <= busy_d;
        end
    end

    assign mem_req   = memReq_q;
    assign mem_we    = memWe_q;
    assign mem_addr  = memAddr_q;
    assign mem_wdata = memWdata_q;
    assign mem_wstrb = memWstrb_q;
    assign mdr       = mdr_q;
    assign done      = done_q;
    assign err       = err_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_lsu_mem_port.sv
// Scoreboard bench for lsu_mem_port: stimulus pushes expected memory requests and
// completions into queues, a negedge monitor pops and compares them.
module tb_lsu_mem_port;

    localparam int TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        req;
    logic        we;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic [31:0] mdr;
    logic        done;
    logic        err;
    logic        busy;

    typedef struct {
        logic        err;
        logic [31:0] mdr;
        int          cyc;
        int          len;
    } doneExp_t;

    typedef struct {
        logic        isStore;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } memExp_t;

    doneExp_t doneQ[$];
    memExp_t  memQ[$];

    int testsRun  = 0;
    int failCount = 0;
    int cycleCnt  = 0;

    lsu_mem_port #(
        .TIMEOUT(TIMEOUT),
        .CNT_W  (5)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .we       (we),
        .funct3   (funct3),
        .addr     (addr),
        .wdata    (wdata),
        .mem_req  (mem_req),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb),
        .mem_rdata(mem_rdata),
        .mem_ack  (mem_ack),
        .mdr      (mdr),
        .done     (done),
        .err      (err),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    initial begin
        forever begin
            @(posedge clk);
            cycleCnt = cycleCnt + 1;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        testsRun = testsRun + 1;
        if (act !== exp) begin
            failCount = failCount + 1;
            $display("[TB] FAIL %s actual=0x%08h required=0x%08h (cycle %0d)", name, act, exp, cycleCnt);
        end
    endtask

    // Monitor: compares every memory request and every completion against the queues.
    initial begin
        logic     prevReq;
        int       reqRises;
        int       reqLen;
        doneExp_t d;
        memExp_t  m;
        prevReq  = 1'b0;
        reqRises = 0;
        reqLen   = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prevReq  = 1'b0;
                reqRises = 0;
                reqLen   = 0;
            end else begin
                if (mem_req && !prevReq) begin
                    reqRises = reqRises + 1;
                    reqLen   = 0;
                    if (memQ.size() == 0) begin
                        checkOutput("unexpectedMemReq", 32'(mem_req), 32'd0);
                    end else begin
                        m = memQ.pop_front();
                        checkOutput("memWe", 32'(mem_we), 32'(m.isStore));
                        checkOutput("memAddr", mem_addr, m.addr);
                        checkOutput("memWstrb", 32'(mem_wstrb), 32'(m.wstrb));
                        if (m.isStore) checkOutput("memWdata", mem_wdata, m.wdata);
                    end
                end
                if (mem_req) reqLen = reqLen + 1;
                if (err && !done) checkOutput("errWithoutDone", 32'(done), 32'd1);
                if (done) begin
                    if (doneQ.size() == 0) begin
                        checkOutput("unexpectedDone", 32'(done), 32'd0);
                    end else begin
                        d = doneQ.pop_front();
                        checkOutput("err", 32'(err), 32'(d.err));
                        checkOutput("mdr", mdr, d.mdr);
                        checkOutput("doneCycle", 32'(cycleCnt), 32'(d.cyc));
                        checkOutput("memReqCount", 32'(reqRises), (d.len > 0) ? 32'd1 : 32'd0);
                        if (d.len > 0) checkOutput("memReqLength", 32'(reqLen), 32'(d.len));
                    end
                    reqRises = 0;
                end
                prevReq = mem_req;
            end
        end
    end

    // ackAt: 0 = command expected to be rejected, -1 = never ack, n = ack in WAIT cycle n.
    task automatic applyStimulus(input logic isStore, input logic [2:0] f3, input logic [31:0] a,
                                 input logic [31:0] wd, input logic [31:0] rd, input int ackAt,
                                 input logic pulseReq, input logic expErr, input logic [31:0] expMdr,
                                 input logic [3:0] expWstrb, input logic [31:0] expWdata);
        int       curCyc;
        int       waitLen;
        logic     seen;
        doneExp_t d;
        memExp_t  m;
        @(negedge clk);
        req     = 1'b1;
        we      = isStore;
        funct3  = f3;
        addr    = a;
        wdata   = wd;
        mem_ack = 1'b0;
        curCyc  = cycleCnt;
        waitLen = (ackAt > 0) ? ackAt : ((ackAt < 0) ? TIMEOUT : 0);
        d.err = expErr;
        d.mdr = expMdr;
        d.cyc = curCyc + 1 + waitLen;
        d.len = waitLen;
        doneQ.push_back(d);
        if (ackAt != 0) begin
            m.isStore = isStore;
            m.addr    = {a[31:2], 2'b00};
            m.wdata   = expWdata;
            m.wstrb   = expWstrb;
            memQ.push_back(m);
        end
        @(negedge clk);
        req    = 1'b0;
        we     = ~isStore;
        funct3 = ~f3;
        addr   = ~a;
        wdata  = ~wd;
        if (ackAt == 0) begin
            checkOutput("rejectNoMemReq", 32'(mem_req), 32'd0);
            @(negedge clk);
            return;
        end
        checkOutput("busyInWait", 32'(busy), 32'd1);
        seen = 1'b0;
        for (int j = 1; j <= TIMEOUT + 4 && !seen; j++) begin
            req       = pulseReq && (ackAt < 0 || j < ackAt);
            mem_ack   = (j == ackAt);
            mem_rdata = (j == ackAt) ? rd : (32'hDEAD_0000 | 32'(j));
            @(negedge clk);
            mem_ack = 1'b0;
            req     = 1'b0;
            if (done) seen = 1'b1;
        end
        checkOutput("doneSeen", 32'(seen), 32'd1);
        checkOutput("busyAfterDone", 32'(busy), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog actual=still running required=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst       = 1'b1;
        req       = 1'b0;
        we        = 1'b0;
        funct3    = 3'b000;
        addr      = 32'h0;
        wdata     = 32'h0;
        mem_rdata = 32'h0;
        mem_ack   = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("resetMdr", mdr, 32'h0);
        checkOutput("resetDone", 32'(done), 32'd0);
        checkOutput("resetErr", 32'(err), 32'd0);
        checkOutput("resetMemReq", 32'(mem_req), 32'd0);
        checkOutput("resetMemAddr", mem_addr, 32'h0);
        checkOutput("resetMemWstrb", 32'(mem_wstrb), 32'd0);
        checkOutput("resetBusy", 32'(busy), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Stores: SW, SB, SH.
        applyStimulus(1'b1, 3'b010, 32'h0000_0104, 32'hDEAD_BEEF, 32'h0, 3, 1'b0, 1'b0, 32'h0, 4'b1111, 32'hDEAD_BEEF);
        applyStimulus(1'b1, 3'b000, 32'h0000_0203, 32'h0000_00A5, 32'h0, 1, 1'b0, 1'b0, 32'h0, 4'b1000, 32'hA5A5_A5A5);
        applyStimulus(1'b1, 3'b001, 32'h0000_0202, 32'h0000_1234, 32'h0, 2, 1'b0, 1'b0, 32'h0, 4'b1100, 32'h1234_1234);

        // Loads from 0x80F17F02.
        applyStimulus(1'b0, 3'b000, 32'h1, 32'h0, 32'h80F1_7F02, 1, 1'b0, 1'b0, 32'h0000_007F, 4'b0000, 32'h0);
        applyStimulus(1'b0, 3'b000, 32'h3, 32'h0, 32'h80F1_7F02, 1, 1'b0, 1'b0, 32'hFFFF_FF80, 4'b0000, 32'h0);
        applyStimulus(1'b0, 3'b100, 32'h3, 32'h0, 32'h80F1_7F02, 2, 1'b0, 1'b0, 32'h0000_0080, 4'b0000, 32'h0);
        applyStimulus(1'b0, 3'b001, 32'h2, 32'h0, 32'h80F1_7F02, 1, 1'b0, 1'b0, 32'hFFFF_80F1, 4'b0000, 32'h0);
        applyStimulus(1'b0, 3'b101, 32'h2, 32'h0, 32'h80F1_7F02, 1, 1'b0, 1'b0, 32'h0000_80F1, 4'b0000, 32'h0);
        applyStimulus(1'b0, 3'b010, 32'h0, 32'h0, 32'h80F1_7F02, 1, 1'b0, 1'b0, 32'h80F1_7F02, 4'b0000, 32'h0);

        // Rejected commands leave the MDR alone.
        applyStimulus(1'b0, 3'b010, 32'h0000_0102, 32'h0, 32'h0, 0, 1'b0, 1'b1, 32'h80F1_7F02, 4'b0000, 32'h0);
        applyStimulus(1'b0, 3'b011, 32'h0, 32'h0, 32'h0, 0, 1'b0, 1'b1, 32'h80F1_7F02, 4'b0000, 32'h0);
        applyStimulus(1'b1, 3'b100, 32'h0, 32'h0, 32'h0, 0, 1'b0, 1'b1, 32'h80F1_7F02, 4'b0000, 32'h0);
        applyStimulus(1'b1, 3'b001, 32'h0000_0011, 32'h0, 32'h0, 0, 1'b0, 1'b1, 32'h80F1_7F02, 4'b0000, 32'h0);

        // Timeout, then ack on the last permitted WAIT cycle.
        applyStimulus(1'b0, 3'b010, 32'h0000_0010, 32'h0, 32'h0, -1, 1'b0, 1'b1, 32'h80F1_7F02, 4'b0000, 32'h0);
        applyStimulus(1'b0, 3'b010, 32'h0000_0020, 32'h0, 32'h1357_9BDF, TIMEOUT, 1'b0, 1'b0, 32'h1357_9BDF, 4'b0000, 32'h0);

        // Reset in the second WAIT cycle of a load aborts without done.
        begin
            memExp_t m;
            @(negedge clk);
            req    = 1'b1;
            we     = 1'b0;
            funct3 = 3'b010;
            addr   = 32'h0000_0040;
            m.isStore = 1'b0;
            m.addr    = 32'h0000_0040;
            m.wdata   = 32'h0;
            m.wstrb   = 4'b0000;
            memQ.push_back(m);
            @(negedge clk);
            req = 1'b0;
            @(negedge clk);
            rst = 1'b1;
            @(negedge clk);
            checkOutput("abortMemReq", 32'(mem_req), 32'd0);
            checkOutput("abortMdr", mdr, 32'h0);
            checkOutput("abortDone", 32'(done), 32'd0);
            checkOutput("abortBusy", 32'(busy), 32'd0);
            rst = 1'b0;
            repeat (3) @(negedge clk);
        end

        // Normal load after reset, with req pulses during WAIT that must be ignored.
        applyStimulus(1'b0, 3'b100, 32'h0000_0042, 32'h0, 32'hAABB_CCDD, 4, 1'b1, 1'b0, 32'h0000_00BB, 4'b0000, 32'h0);

        // An ack while idle must not produce a completion or touch the MDR.
        @(negedge clk);
        mem_ack   = 1'b1;
        mem_rdata = 32'hFFFF_FFFF;
        @(negedge clk);
        mem_ack = 1'b0;
        @(negedge clk);
        checkOutput("idleAckMdr", mdr, 32'h0000_00BB);
        checkOutput("idleAckBusy", 32'(busy), 32'd0);

        repeat (3) @(negedge clk);
        checkOutput("doneQueueDrained", 32'(doneQ.size()), 32'd0);
        checkOutput("memQueueDrained", 32'(memQ.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule
